// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 stream router with a 2-entry FIFO on each output.
//
// Each incoming word is steered by in_sel to out0 (sel=0) or out1 (sel=1).
// Every output owns a small FIFO, so a stalled consumer only blocks words
// bound for itself. All handshakes are valid/ready. A per-output counter
// tracks how many words have been accepted for that output.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_data     input word (WIDTH bits)
//   in_sel      destination of the current word (0 = out0, 1 = out1)
//   in_valid    in_data/in_sel are valid
//   in_ready    block can accept the current word (depends on in_sel)
//   out0_data   head word of the out0 FIFO
//   out0_valid  out0 FIFO non-empty
//   out0_ready  out0 consumer accepts the head word
//   out1_data   head word of the out1 FIFO
//   out1_valid  out1 FIFO non-empty
//   out1_ready  out1 consumer accepts the head word
//   cnt0        words accepted for out0 (wraps)
//   cnt1        words accepted for out1 (wraps)
module stream_demux #(
  parameter int WIDTH     = 9,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  // FIFO storage and bookkeeping for each output
  logic [WIDTH-1:0] mem0 [2];
  logic [WIDTH-1:0] mem1 [2];
  logic             rd_ptr0, wr_ptr0;
  logic             rd_ptr1, wr_ptr1;
  logic [1:0]       occ0, occ1;

  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;

  assign full0 = (occ0 == 2'd2);
  assign full1 = (occ1 == 2'd2);

  // Readiness follows the FIFO the current word is aimed at. There is no
  // bypass: a full FIFO refuses a push even when it is popped this cycle.
  assign in_ready = in_sel ? !full1 : !full0;

  assign push0 = in_valid && !in_sel && !full0;
  assign push1 = in_valid &&  in_sel && !full1;

  // Outputs come only from registered state, never from the input side
  assign out0_valid = (occ0 != 2'd0);
  assign out1_valid = (occ1 != 2'd0);
  assign out0_data  = mem0[rd_ptr0];
  assign out1_data  = mem1[rd_ptr1];

  assign pop0 = out0_valid && out0_ready;
  assign pop1 = out1_valid && out1_ready;

  // out0 FIFO and its accepted-word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem0[0] <= '0;
      mem0[1] <= '0;
      rd_ptr0 <= 1'b0;
      wr_ptr0 <= 1'b0;
      occ0    <= 2'd0;
      cnt0    <= '0;
    end else begin
      if (push0) begin
        mem0[wr_ptr0] <= in_data;
        wr_ptr0       <= ~wr_ptr0;
        cnt0          <= cnt0 + CNT_WIDTH'(1);
      end
      if (pop0) begin
        rd_ptr0 <= ~rd_ptr0;
      end
      // Simultaneous push and pop leaves occupancy unchanged
      case ({push0, pop0})
        2'b10:   occ0 <= occ0 + 2'd1;
        2'b01:   occ0 <= occ0 - 2'd1;
        default: occ0 <= occ0;
      endcase
    end
  end

  // out1 FIFO and its accepted-word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem1[0] <= '0;
      mem1[1] <= '0;
      rd_ptr1 <= 1'b0;
      wr_ptr1 <= 1'b0;
      occ1    <= 2'd0;
      cnt1    <= '0;
    end else begin
      if (push1) begin
        mem1[wr_ptr1] <= in_data;
        wr_ptr1       <= ~wr_ptr1;
        cnt1          <= cnt1 + CNT_WIDTH'(1);
      end
      if (pop1) begin
        rd_ptr1 <= ~rd_ptr1;
      end
      case ({push1, pop1})
        2'b10:   occ1 <= occ1 + 2'd1;
        2'b01:   occ1 <= occ1 - 2'd1;
        default: occ1 <= occ1;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed, table-driven bench for stream_demux.
module tb_stream_demux;

  logic       clk;
  logic       rst_n;
  logic [8:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [8:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int checks;
  int errors;

  stream_demux #(.WIDTH(9), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: inputs for a cycle, expected in_ready before the edge,
  // expected registered outputs after the edge
  typedef struct {
    logic [8:0] data;
    logic       sel;
    logic       valid;
    logic       r0;
    logic       r1;
    logic       exp_rdy;
    logic       exp_v0;
    logic [8:0] exp_d0;
    logic       exp_v1;
    logic [8:0] exp_d1;
    logic [7:0] exp_c0;
    logic [7:0] exp_c1;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [8:0] data, input logic sel, input logic valid,
                              input logic r0, input logic r1, input logic exp_rdy,
                              input logic exp_v0, input logic [8:0] exp_d0,
                              input logic exp_v1, input logic [8:0] exp_d1,
                              input logic [7:0] exp_c0, input logic [7:0] exp_c1);
    vec_t v;
    v.data = data;     v.sel = sel;       v.valid = valid;
    v.r0 = r0;         v.r1 = r1;         v.exp_rdy = exp_rdy;
    v.exp_v0 = exp_v0; v.exp_d0 = exp_d0;
    v.exp_v1 = exp_v1; v.exp_d1 = exp_d1;
    v.exp_c0 = exp_c0; v.exp_c1 = exp_c1;
    return v;
  endfunction

  // Drive inputs on the falling edge and let combinational paths settle
  task automatic applyStimulus(input logic [8:0] d, input logic s, input logic v,
                               input logic r0, input logic r1);
    @(negedge clk);
    in_data    = d;
    in_sel     = s;
    in_valid   = v;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Reset then idle
    doReset(2);
    checkOutput("reset out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("reset out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("reset out0_data", 32'(out0_data), 32'd0);
    checkOutput("reset out1_data", 32'(out1_data), 32'd0);
    checkOutput("reset cnt0", 32'(cnt0), 32'd0);
    checkOutput("reset cnt1", 32'(cnt1), 32'd0);
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset in_ready sel0", 32'(in_ready), 32'd1);
    applyStimulus(9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset in_ready sel1", 32'(in_ready), 32'd1);

    // Routing, backpressure/full, independence, no-bypass
    //             data    sel   vld   r0    r1    rdy   v0    d0      v1    d1      c0     c1
    vecs[0]  = mk(9'h0A5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b0, 9'h000, 8'd1, 8'd0);
    vecs[1]  = mk(9'h15A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 9'h15A, 8'd1, 8'd1);
    vecs[2]  = mk(9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 8'd1, 8'd1);
    vecs[3]  = mk(9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 9'h001, 8'd1, 8'd2);
    vecs[4]  = mk(9'h002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 9'h001, 8'd1, 8'd3);
    vecs[5]  = mk(9'h003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h001, 8'd1, 8'd3);
    vecs[6]  = mk(9'h003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 9'h001, 8'd1, 8'd3);
    vecs[7]  = mk(9'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 9'h100, 1'b1, 9'h001, 8'd2, 8'd3);
    vecs[8]  = mk(9'h003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h002, 8'd2, 8'd3);
    vecs[9]  = mk(9'h003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 9'h003, 8'd2, 8'd4);
    vecs[10] = mk(9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 8'd2, 8'd4);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].data, vecs[i].sel, vecs[i].valid, vecs[i].r0, vecs[i].r1);
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      checkOutput($sformatf("vec%0d out0_valid", i), 32'(out0_valid), 32'(vecs[i].exp_v0));
      checkOutput($sformatf("vec%0d out1_valid", i), 32'(out1_valid), 32'(vecs[i].exp_v1));
      if (vecs[i].exp_v0)
        checkOutput($sformatf("vec%0d out0_data", i), 32'(out0_data), 32'(vecs[i].exp_d0));
      if (vecs[i].exp_v1)
        checkOutput($sformatf("vec%0d out1_data", i), 32'(out1_data), 32'(vecs[i].exp_d1));
      checkOutput($sformatf("vec%0d cnt0", i), 32'(cnt0), 32'(vecs[i].exp_c0));
      checkOutput($sformatf("vec%0d cnt1", i), 32'(cnt1), 32'(vecs[i].exp_c1));
    end

    // Simultaneous push/pop: preload one word, then stream at full rate
    applyStimulus(9'h050, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("pp preload valid", 32'(out0_valid), 32'd1);
    checkOutput("pp preload data", 32'(out0_data), 32'h050);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(9'(9'h050 + i), 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("pp%0d in_ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("pp%0d head before", i), 32'(out0_data), 32'(9'h050 + i - 1));
      tick();
      checkOutput($sformatf("pp%0d valid", i), 32'(out0_valid), 32'd1);
      checkOutput($sformatf("pp%0d head after", i), 32'(out0_data), 32'(9'h050 + i));
    end
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("pp drained valid", 32'(out0_valid), 32'd0);
    checkOutput("pp cnt0", 32'(cnt0), 32'd13);

    // Counter wrap after 256 accepted words
    doReset(1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(9'(i), 1'b0, 1'b1, 1'b1, 1'b1);
      if (i == 255)
        checkOutput("wrap cnt0 before last", 32'(cnt0), 32'd255);
      tick();
    end
    checkOutput("wrap cnt0", 32'(cnt0), 32'd0);
    checkOutput("wrap cnt1", 32'(cnt1), 32'd0);
    checkOutput("wrap last data", 32'(out0_data), 32'h0FF);
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Fill both FIFOs, then reset mid-operation
    applyStimulus(9'h011, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(9'h012, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(9'h021, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(9'h022, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full in_ready sel0", 32'(in_ready), 32'd0);
    applyStimulus(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full in_ready sel1", 32'(in_ready), 32'd0);
    checkOutput("full head0", 32'(out0_data), 32'h011);
    checkOutput("full head1", 32'(out1_data), 32'h021);
    checkOutput("full cnt0", 32'(cnt0), 32'd2);
    checkOutput("full cnt1", 32'(cnt1), 32'd2);
    doReset(1);
    checkOutput("midreset out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("midreset out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("midreset out0_data", 32'(out0_data), 32'd0);
    checkOutput("midreset out1_data", 32'(out1_data), 32'd0);
    checkOutput("midreset cnt0", 32'(cnt0), 32'd0);
    checkOutput("midreset cnt1", 32'(cnt1), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-2 routing block, the opposite direction of the 2:1 selection path.
- Steers one 9-bit input stream to one of two output streams, per word, using a select bit presented with the word. Example payloads are sensor/vehicle-count words going to two lane controllers.
- Each output has a 2-entry FIFO, so a stalled destination does not block words bound for the other one.
- Uses valid/ready handshakes on all sides and keeps a per-output count of delivered words.

Parameters:
- WIDTH, 9: data word width.
- CNT_WIDTH, 8: width of the per-output accepted-word counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination of the current word: 0 = out0, 1 = out1.
- in_valid  input  1  in_data/in_sel are valid.
- in_ready  output  1  block can accept the current word.
- out0_data  output  WIDTH  head word of the out0 FIFO.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  out0 consumer accepts the head word.
- out1_data  output  WIDTH  head word of the out1 FIFO.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  out1 consumer accepts the head word.
- cnt0  output  CNT_WIDTH  number of words accepted for out0.
- cnt1  output  CNT_WIDTH  number of words accepted for out1.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Both FIFOs are emptied and their pointers cleared.
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0.
  - Reset mid-operation silently discards all buffered words.
- in_ready is combinational: in_sel ? !full1 : !full0. It may toggle with in_sel while in_valid is held.
- Accept condition: in_valid && in_ready at a clk edge. The word is pushed into the FIFO selected by in_sel, and cntX for that FIFO increments by 1.
- Counter wrap: 2^CNT_WIDTH-1 rolls over to 0. No saturation.
- FIFO organisation: each FIFO has 2 entries, a 1-bit read pointer, a 1-bit write pointer, and a 2-bit occupancy count (0..2).
  - full = (occupancy == 2).
  - outX_valid = (occupancy != 0).
  - outX_data is the entry at the read pointer.
  - Both outX_valid and outX_data come straight from registers, with no input-to-output combinational path.
- Latency: a word accepted at edge N is visible on outX_data with outX_valid = 1 after edge N (cycle N+1) if the FIFO was empty. Otherwise it appears behind the older words.
- Pop: outX_valid && outX_ready at an edge advances the read pointer and decrements occupancy.
- Push and pop on the same FIFO in the same edge: occupancy is unchanged and both pointers advance.
- Full FIFO: no push, even if a pop happens in the same cycle. in_ready already reflects full, and there is no bypass.
- Stability: while outX_valid = 1 and outX_ready = 0, outX_data and outX_valid hold stable.
- Ordering: preserved per output. There is no ordering relation between out0 and out1.
- Independence: a stalled out1 never blocks words with in_sel = 0, and vice versa.
- Empty-FIFO data value: outX_data shows the stale entry at the read pointer. It is 0 only after reset, and is don't-care while valid = 0.
- Inputs when idle: in_sel and in_data are ignored when in_valid = 0.

Test Plan:
- Reset then idle: hold rst_n = 0 for 2 cycles, release. Expect out0_valid = out1_valid = 0, cnt0 = cnt1 = 0, in_ready = 1 for both in_sel values.
- Routing: send 0x0A5 with sel = 0, then 0x15A with sel = 1, both outputs ready. Expect out0 to deliver 0x0A5 one cycle after its accept and out1 to deliver 0x15A one cycle after its accept. Expect cnt0 = 1 and cnt1 = 1.
- Backpressure / full: hold out1_ready = 0 and send 0x001, 0x002, 0x003 with sel = 1. Expect the first two accepted, then in_ready = 0 with 0x003 held. Then raise out1_ready and expect order 0x001, 0x002, 0x003 with no loss. Expect cnt1 = 3.
- Independence: with out1 full and stalled, send 0x100 with sel = 0. Expect in_ready = 1, accept, and 0x100 on out0 next cycle.
- Simultaneous push/pop: with out0 holding 1 word and out0_ready = 1, push with sel = 0 every cycle for 10 cycles. Expect occupancy to stay at 1 and full-rate throughput with in-order data.
- Wrap and mid-reset: accept 256 words with sel = 0 (CNT_WIDTH = 8) and expect cnt0 = 0. Fill both FIFOs, assert rst_n = 0 for one cycle, and expect both valids = 0 and the counters = 0 on the next cycle.
